dec_deserializer: RTL and testbench

Receive-side counterpart of the decimator's 22-bit serial output. It samples the serial data stream and its frame_sync qualifier, rebuilds each output word, and presents the word in parallel with a one-cycle valid strobe. It sits in the bench or downstream logic that consumes the decimator output, such as a verification harness, an FPGA capture block, or a second on-chip consumer. It detects malformed frames and counts good ones.

---
 rtl/dec_ser_pkg.sv | 5 +
 rtl/dec_deserializer_sync.sv | 19 +
 rtl/dec_deserializer.sv | 73 +++++++
 tb/tb_dec_deserializer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dec_ser_pkg.sv
// dec_ser_pkg: frame length and receiver state encoding shared with the decimator serializer
package dec_ser_pkg;
  localparam int DEC_WORD_W = 22;
  typedef enum logic [1:0] {WAIT_LOW, IDLE, RECV} state_t;
endpackage

// File: rtl/dec_deserializer_sync.sv
// dec_deserializer_sync: N-stage flop synchronizer for a bus of asynchronous inputs
module dec_deserializer_sync #(
  parameter int N_STAGES = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] s [N_STAGES];
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) for (int i = 0; i < N_STAGES; i++) s[i] <= '0;
    else begin
      s[0] <= d;
      for (int i = 1; i < N_STAGES; i++) s[i] <= s[i-1];
    end
  assign q = s[N_STAGES-1];
endmodule

// File: rtl/dec_deserializer.sv
// dec_deserializer: rebuilds framed MSB-first serial words, flags short/long frames, counts good ones
module dec_deserializer
  import dec_ser_pkg::*;
#(
  parameter int DATA_W      = DEC_WORD_W,
  parameter int SYNC_STAGES = 0,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              ser_i,
  input  logic              frame_sync_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_strobe,
  output logic              err_short,
  output logic              err_long,
  output logic              err_sticky,
  output logic [CNT_W-1:0]  frame_cnt
);
  localparam int BW = $clog2(DATA_W + 1);
  logic ser, fs;
  generate
    if (SYNC_STAGES > 0) begin : g_sync
      dec_deserializer_sync #(.N_STAGES(SYNC_STAGES), .W(2)) u_sync (
        .clk  (clk),
        .rst_b(rst_b),
        .d    ({ser_i, frame_sync_i}),
        .q    ({ser, fs})
      );
    end else begin : g_bypass
      assign ser = ser_i;
      assign fs  = frame_sync_i;
    end
  endgenerate
  state_t state, state_nx;
  logic [DATA_W-1:0] sr;
  logic [BW-1:0] cnt;
  logic full, good, short_e, long_e;
  assign full = cnt == BW'(DATA_W);
  always_comb begin
    good     = state == RECV && !fs && full;
    short_e  = state == RECV && !fs && !full;
    long_e   = state == RECV && fs && full;
    state_nx = state == WAIT_LOW ? (fs ? WAIT_LOW : IDLE) :
               state == IDLE     ? (fs ? RECV : IDLE) :
               long_e            ? WAIT_LOW :
               fs                ? RECV : IDLE;
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state <= WAIT_LOW;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      sr           <= '0;
      cnt          <= '0;
      data_o       <= '0;
      valid_strobe <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
      err_sticky   <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      sr           <= (state != WAIT_LOW && fs) ? {sr[DATA_W-2:0], ser} : sr;
      cnt          <= (state == IDLE && fs) ? BW'(1) : (state == RECV && fs && !full) ? cnt + 1'b1 : cnt;
      data_o       <= good ? sr : data_o;
      valid_strobe <= good;
      err_short    <= short_e;
      err_long     <= long_e;
      err_sticky   <= short_e | long_e | (err_sticky & ~clr_i);
      frame_cnt    <= (clr_i ? '0 : frame_cnt) + CNT_W'(good);
    end
endmodule

// File: tb/tb_dec_deserializer.sv
// tb_dec_deserializer: table-driven frames with an event scoreboard for a direct and a 2-stage-synchronized receiver
module tb_dec_deserializer;
  logic clk = 0, rst_b = 0, ser = 0, fs = 0, clr = 0;
  logic [21:0] d0, d2;
  logic v0, es0, el0, st0, v2, es2, el2, st2;
  logic [15:0] c0;
  logic [3:0] c2;
  always #5 clk = ~clk;

  dec_deserializer #(.SYNC_STAGES(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_b(rst_b), .ser_i(ser), .frame_sync_i(fs), .clr_i(clr),
    .data_o(d0), .valid_strobe(v0), .err_short(es0), .err_long(el0),
    .err_sticky(st0), .frame_cnt(c0));
  dec_deserializer #(.SYNC_STAGES(2), .CNT_W(4)) u2 (
    .clk(clk), .rst_b(rst_b), .ser_i(ser), .frame_sync_i(fs), .clr_i(clr),
    .data_o(d2), .valid_strobe(v2), .err_short(es2), .err_long(el2),
    .err_sticky(st2), .frame_cnt(c2));

  typedef struct {int kind; logic [21:0] data; logic [15:0] cnt; int cyc;} ev_t;
  typedef struct {logic [21:0] w; int nh; int k; int gap;} vec_t;
  ev_t q0[$], q2[$];
  int total = 0, bad = 0, cyc = 0, pv = 0, lv = 0;
  logic [21:0] last0 = 0, last2 = 0;
  logic [15:0] ec0 = 0;
  logic [3:0] ec2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic ev_check(input string t, input logic v, input logic s, input logic l, input logic st,
                          input logic [21:0] d, input logic [15:0] c, input ev_t e, input logic [21:0] last);
    chk({t, "_one_flag"}, int'(v) + int'(s) + int'(l), 1);
    chk({t, "_kind"}, v ? 0 : s ? 1 : 2, e.kind);
    chk({t, "_cycle"}, cyc, e.cyc);
    chk({t, "_data"}, {10'b0, d}, {10'b0, e.kind == 0 ? e.data : last});
    chk({t, "_cnt"}, {16'b0, c}, {16'b0, e.cnt});
    if (e.kind != 0) chk({t, "_sticky"}, st, 1);
  endtask

  always @(negedge clk) if (rst_b) begin
    ev_t e;
    if (v0 | es0 | el0) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL u0_unexpected_event: got v=%b s=%b l=%b want none", v0, es0, el0);
      end else begin
        e = q0.pop_front();
        ev_check("u0", v0, es0, el0, st0, d0, c0, e, last0);
        if (e.kind == 0) begin last0 = e.data; pv = lv; lv = cyc; end
      end
    end
    if (v2 | es2 | el2) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL u2_unexpected_event: got v=%b s=%b l=%b want none", v2, es2, el2);
      end else begin
        e = q2.pop_front();
        ev_check("u2", v2, es2, el2, st2, d2, {12'b0, c2}, e, last2);
        if (e.kind == 0) last2 = e.data;
      end
    end
  end

  task automatic push(input int k, input logic [21:0] w);
    ev_t e;
    if (k == 0) begin ec0++; ec2++; end
    e.kind = k; e.data = w; e.cnt = ec0; e.cyc = cyc + 1;
    q0.push_back(e);
    e.cnt = {12'b0, ec2}; e.cyc = cyc + 3;
    q2.push_back(e);
  endtask

  task automatic send(input logic [21:0] w, input int nh, input int k, input int gap, input logic clr_end);
    for (int i = 0; i < nh; i++) begin
      @(negedge clk);
      fs = 1; clr = 0;
      if (i < 22) ser = w[21-i];
      else ser = 1'($urandom);
      if (i == 22 && k == 2) push(2, w);
    end
    @(negedge clk);
    fs = 0; ser = 0;
    if (clr_end) begin clr = 1; ec0 = 0; ec2 = 0; end
    if (k != 2) push(k, w);
    for (int i = 1; i < gap; i++) begin @(negedge clk); clr = 0; end
  endtask

  task automatic drain;
    int n = 0;
    while ((q0.size() != 0 || q2.size() != 0) && n < 100) begin
      @(negedge clk); clr = 0; n++;
    end
    @(negedge clk); clr = 0;
    chk("drain_q0", q0.size(), 0);
    chk("drain_q2", q2.size(), 0);
  endtask

  initial begin
    vec_t tbl[11];
    ev_t e2;
    tbl[0]  = '{22'h2ABCDE, 22, 0, 3};
    tbl[1]  = '{22'h3FFFFF, 22, 0, 1};
    tbl[2]  = '{22'h000001, 22, 0, 2};
    tbl[3]  = '{22'h1234AB, 15, 1, 2};
    tbl[4]  = '{22'h155555, 22, 0, 2};
    tbl[5]  = '{22'h0F0F0F, 30, 2, 1};
    tbl[6]  = '{22'h2AAAAA, 22, 0, 1};
    tbl[7]  = '{22'h111111, 44, 2, 2};
    tbl[8]  = '{22'h3C3C3C, 22, 0, 2};
    tbl[9]  = '{22'h000000,  1, 1, 2};
    tbl[10] = '{22'h200000, 22, 0, 2};

    repeat (3) @(negedge clk);
    rst_b = 1;
    repeat (2) @(negedge clk);
    chk("rst_data0", {10'b0, d0}, 0);
    chk("rst_flags0", {v0, es0, el0, st0}, 0);
    chk("rst_cnt0", {16'b0, c0}, 0);
    chk("rst_data2", {10'b0, d2}, 0);
    chk("rst_flags2", {v2, es2, el2, st2}, 0);
    chk("rst_cnt2", {28'b0, c2}, 0);

    foreach (tbl[i]) send(tbl[i].w, tbl[i].nh, tbl[i].k, tbl[i].gap, 0);
    drain();

    send(22'h3FFFFF, 22, 0, 1, 0);
    send(22'h000001, 22, 0, 1, 0);
    drain();
    chk("b2b_spacing", lv - pv, 23);
    chk("b2b_data", {10'b0, d0}, 1);

    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0; ec0 = 0; ec2 = 0;
    chk("clr_sticky0", st0, 0);
    chk("clr_cnt0", {16'b0, c0}, 0);
    chk("clr_sticky2", st2, 0);
    chk("clr_cnt2", {28'b0, c2}, 0);

    send(22'h2ABCDE, 22, 0, 2, 1);
    drain();
    chk("clr_good_cnt0", {16'b0, c0}, 1);
    chk("clr_good_sticky0", st0, 0);
    send(22'h0000FF, 10, 1, 2, 1);
    drain();
    chk("clr_err_sticky0", st0, 1);
    chk("clr_err_sticky2", st2, 1);
    chk("clr_err_cnt0", {16'b0, c0}, 0);

    for (int i = 0; i < 10; i++) begin @(negedge clk); fs = 1; ser = 1'($urandom); end
    @(negedge clk);
    rst_b = 0;
    q0.delete(); q2.delete();
    ec0 = 0; ec2 = 0; last0 = 0; last2 = 0;
    @(negedge clk);
    chk("midrst_cnt0", {16'b0, c0}, 0);
    chk("midrst_sticky0", st0, 0);
    @(negedge clk);
    rst_b = 1;
    for (int i = 0; i < 10; i++) begin @(negedge clk); ser = 1'($urandom); end
    @(negedge clk);
    fs = 0; ser = 0;
    // the 2-stage synchronizer comes out of reset holding 0, so u2 sees the frame tail as a short frame
    e2.kind = 1; e2.data = 0; e2.cnt = 0; e2.cyc = cyc + 3;
    q2.push_back(e2);
    @(negedge clk);
    send(22'h2ABCDE, 22, 0, 2, 0);
    drain();
    chk("midrst_data0", {10'b0, d0}, 32'h2ABCDE);
    chk("midrst_cnt0b", {16'b0, c0}, 1);

    for (int i = 0; i < 15; i++) send(22'($urandom), 22, 0, 1, 0);
    drain();
    chk("wrap_cnt2", {28'b0, c2}, 0);
    chk("wrap_cnt0", {16'b0, c0}, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
